// File: rtl/int_responder.sv
// Interrupt responder: takes encoder break/code at instruction boundaries, grants, vectors and handles ERET.
// Optional macro NESTED_INT_EN enables an EPC/INM stack for preemptive nesting.
module int_responder #(
    parameter int          PC_W        = 32,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0800,
    parameter int          VEC_STRIDE  = 4,
    parameter int          STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            in_RST,
    input  logic            in_break,
    input  logic [1:0]      in_code,
    input  logic            in_instr_done,
    input  logic [PC_W-1:0] in_pc,
    input  logic            in_eret,
    input  logic            in_ie_set,
    input  logic            in_ie_clr,
    output logic            out_IE,
    output logic [3:0]      out_INM,
    output logic [3:0]      out_IG,
    output logic            out_hold,
    output logic            out_jump,
    output logic [PC_W-1:0] out_target,
    output logic [2:0]      out_level
);

    // state  | meaning
    // RUN    | normal execution, boundaries evaluated
    // TAKE   | grant pulse to the selected request latch
    // VECTOR | PC load to the handler vector
    // RETURN | PC load to the saved EPC
    typedef enum logic [1:0] {RUN, TAKE, VECTOR, RETURN} state_t;

    state_t          state_q, state_n;
    logic [1:0]      code_q;
    logic            ie_q;
    logic [3:0]      inm_q;
    logic [2:0]      level_q;
    logic            boundary, do_ret, do_take;
    logic [PC_W-1:0] epc_top;
    logic [PC_W-1:0] vec_addr;

`ifdef NESTED_INT_EN
    localparam int LVL_MAX = STACK_DEPTH;
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  epc_stk [STACK_DEPTH];
    logic [3:0]       inm_stk [STACK_DEPTH];
    logic [IDX_W-1:0] idx_push, idx_top;

    assign idx_push = IDX_W'(level_q);
    assign idx_top  = IDX_W'(level_q - 3'd1);
    assign epc_top  = epc_stk[idx_top];

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                epc_stk[i] <= '0;
                inm_stk[i] <= '0;
            end
            inm_q <= '0;
        end else begin
            if (do_take)
                epc_stk[idx_push] <= in_pc;
            if (state_q == VECTOR) begin
                inm_stk[idx_push] <= inm_q;
                // mask the granted level and everything below it
                inm_q <= inm_q | ((4'b0010 << code_q) - 4'd1);
            end
            if (state_q == RETURN)
                inm_q <= inm_stk[idx_top];
        end
    end
`else
    // a single EPC register caps nesting at one level
    localparam int LVL_MAX = (STACK_DEPTH < 1) ? STACK_DEPTH : 1;

    logic [PC_W-1:0] epc_q;

    assign epc_top = epc_q;
    assign inm_q   = '0;

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST)
            epc_q <= '0;
        else if (do_take)
            epc_q <= in_pc;
    end
`endif

    assign boundary = (state_q == RUN) && in_instr_done;
    assign do_ret   = boundary && in_eret && (level_q != 3'd0);
    assign do_take  = boundary && !do_ret && in_break && ie_q && (level_q < 3'(LVL_MAX));
    assign vec_addr = PC_W'(VEC_BASE) + PC_W'(code_q) * PC_W'(VEC_STRIDE);

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST)
            state_q <= RUN;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n    = state_q;
        out_IG     = '0;
        out_jump   = 1'b0;
        out_target = '0;
        case (state_q)
            RUN: begin
                if (do_ret)
                    state_n = RETURN;
                else if (do_take)
                    state_n = TAKE;
            end
            TAKE: begin
                out_IG  = 4'b0001 << code_q;
                state_n = VECTOR;
            end
            VECTOR: begin
                out_jump   = 1'b1;
                out_target = vec_addr;
                state_n    = RUN;
            end
            RETURN: begin
                out_jump   = 1'b1;
                out_target = epc_top;
                state_n    = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            code_q  <= '0;
            ie_q    <= 1'b0;
            level_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (do_take) begin
                        code_q <= in_code;
                        ie_q   <= 1'b0;
                    end else if (boundary && !do_ret) begin
                        if (in_ie_clr)
                            ie_q <= 1'b0;
                        else if (in_ie_set)
                            ie_q <= 1'b1;
                    end
                end
                VECTOR: begin
                    level_q <= level_q + 3'd1;
`ifdef NESTED_INT_EN
                    // a full stack leaves interrupts disabled so it cannot overflow
                    ie_q <= (level_q != 3'(LVL_MAX - 1));
`endif
                end
                RETURN: begin
                    ie_q    <= 1'b1;
                    level_q <= level_q - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_IE    = ie_q;
    assign out_INM   = inm_q;
    assign out_hold  = (state_q != RUN);
    assign out_level = level_q;

endmodule

// File: tb/tb_int_responder.sv
// Self-checking bench for int_responder: directed vector table, corner sequences, random vs reference model.
module tb_int_responder;

    localparam int PC_W = 32;
`ifdef NESTED_INT_EN
    localparam bit NEST = 1'b1;
    localparam int LMAX = 4;
`else
    localparam bit NEST = 1'b0;
    localparam int LMAX = 1;
`endif

    logic            clk = 1'b0;
    logic            in_RST = 1'b1;
    logic            in_break = 1'b0;
    logic [1:0]      in_code = '0;
    logic            in_instr_done = 1'b0;
    logic [PC_W-1:0] in_pc = '0;
    logic            in_eret = 1'b0;
    logic            in_ie_set = 1'b0;
    logic            in_ie_clr = 1'b0;
    logic            out_IE;
    logic [3:0]      out_INM;
    logic [3:0]      out_IG;
    logic            out_hold;
    logic            out_jump;
    logic [PC_W-1:0] out_target;
    logic [2:0]      out_level;

    int n_tests = 0;
    int n_fail  = 0;

    int_responder dut (
        .clk           (clk),
        .in_RST        (in_RST),
        .in_break      (in_break),
        .in_code       (in_code),
        .in_instr_done (in_instr_done),
        .in_pc         (in_pc),
        .in_eret       (in_eret),
        .in_ie_set     (in_ie_set),
        .in_ie_clr     (in_ie_clr),
        .out_IE        (out_IE),
        .out_INM       (out_INM),
        .out_IG        (out_IG),
        .out_hold      (out_hold),
        .out_jump      (out_jump),
        .out_target    (out_target),
        .out_level     (out_level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  ig;
        bit          jump;
        logic [31:0] tgt;
    } slot_t;

    bit          m_ie;
    logic [3:0]  m_inm;
    int          m_level;
    logic [1:0]  m_code;
    int          m_fin;
    logic [31:0] m_epc[$];
    logic [3:0]  m_msk[$];
    slot_t       m_q[$];

    function automatic void model_reset();
        m_ie = 0; m_inm = '0; m_level = 0; m_code = '0; m_fin = 0;
        m_epc.delete(); m_msk.delete(); m_q.delete();
    endfunction

    function automatic void model_step(input bit d, input bit e, input bit s, input bit c,
                                       input bit b, input logic [1:0] code, input logic [31:0] pc);
        if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                if (m_fin == 1) begin
                    if (NEST) begin
                        m_msk.push_back(m_inm);
                        for (int k = 0; k <= int'(m_code); k++) m_inm[k] = 1'b1;
                        m_level++;
                        m_ie = (m_level != LMAX);
                    end else begin
                        m_level++;
                    end
                end else begin
                    void'(m_epc.pop_back());
                    if (NEST) m_inm = m_msk.pop_back();
                    m_ie = 1;
                    m_level--;
                end
                m_fin = 0;
            end
        end else if (d) begin
            if (e && m_level > 0) begin
                m_q.push_back('{ig: 4'b0000, jump: 1'b1, tgt: m_epc[$]});
                m_fin = 2;
            end else if (b && m_ie && m_level < LMAX) begin
                m_code = code;
                m_epc.push_back(pc);
                m_ie = 0;
                m_q.push_back('{ig: 4'(1 << code), jump: 1'b0, tgt: 32'h0});
                m_q.push_back('{ig: 4'b0000, jump: 1'b1, tgt: 32'h800 + 32'(code) * 32'd4});
                m_fin = 1;
            end else if (c) begin
                m_ie = 0;
            end else if (s) begin
                m_ie = 1;
            end
        end
    endfunction

    task automatic check_model();
        bit busy;
        busy = (m_q.size() > 0);
        chk("IE", 32'(out_IE), 32'(m_ie));
        chk("INM", 32'(out_INM), 32'(m_inm));
        chk("hold", 32'(out_hold), 32'(busy));
        chk("level", 32'(out_level), 32'(m_level));
        chk("IG", 32'(out_IG), busy ? 32'(m_q[0].ig) : 32'h0);
        chk("jump", 32'(out_jump), busy ? 32'(m_q[0].jump) : 32'h0);
        if (busy && m_q[0].jump) chk("target", out_target, m_q[0].tgt);
    endtask

    task automatic drive(input bit d, input bit e, input bit s, input bit c,
                         input bit b, input logic [1:0] code, input logic [31:0] pc);
        in_instr_done = d; in_eret = e; in_ie_set = s; in_ie_clr = c;
        in_break = b; in_code = code; in_pc = pc;
    endtask

    task automatic step(input bit d, input bit e, input bit s, input bit c,
                        input bit b, input logic [1:0] code, input logic [31:0] pc);
        drive(d, e, s, c, b, code, pc);
        @(posedge clk);
        model_step(d, e, s, c, b, code, pc);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 2'd0, 32'h0);
        in_RST = 1'b1;
        @(posedge clk);
        #1;
        in_RST = 1'b0;
        model_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit d, e, s, c, b;
        logic [1:0]  code;
        logic [31:0] pc;
        bit          x_ie;
        logic [3:0]  x_inm;
        logic [3:0]  x_ig;
        bit          x_jump;
        logic [31:0] x_tgt;
        bit          x_hold;
        logic [2:0]  x_lvl;
    } vec_t;

    vec_t tbl[13];

    initial begin
        //          d  e  s  c  b  code  pc          ie    inm                     ig       jmp tgt          hold lvl
        tbl[0]  = '{1, 0, 1, 0, 0, 2'd0, 32'h0,      1,    4'b0000,                4'b0000, 0, 32'h0,      0,   3'd0};
        tbl[1]  = '{0, 0, 0, 0, 0, 2'd0, 32'h0,      1,    4'b0000,                4'b0000, 0, 32'h0,      0,   3'd0};
        tbl[2]  = '{1, 0, 0, 0, 1, 2'd2, 32'h100,    0,    4'b0000,                4'b0100, 0, 32'h0,      1,   3'd0};
        tbl[3]  = '{1, 0, 1, 0, 1, 2'd2, 32'h0,      0,    4'b0000,                4'b0000, 1, 32'h808,    1,   3'd0};
        tbl[4]  = '{0, 0, 0, 0, 0, 2'd0, 32'h0,      NEST, NEST ? 4'b0111 : 4'b0,  4'b0000, 0, 32'h0,      0,   3'd1};
        tbl[5]  = '{1, 1, 0, 0, 0, 2'd0, 32'h0,      NEST, NEST ? 4'b0111 : 4'b0,  4'b0000, 1, 32'h100,    1,   3'd1};
        tbl[6]  = '{0, 0, 0, 0, 0, 2'd0, 32'h0,      1,    4'b0000,                4'b0000, 0, 32'h0,      0,   3'd0};
        tbl[7]  = '{1, 1, 1, 1, 0, 2'd0, 32'h0,      0,    4'b0000,                4'b0000, 0, 32'h0,      0,   3'd0};
        tbl[8]  = '{1, 0, 1, 0, 0, 2'd0, 32'h0,      1,    4'b0000,                4'b0000, 0, 32'h0,      0,   3'd0};
        tbl[9]  = '{0, 0, 0, 0, 1, 2'd3, 32'h0,      1,    4'b0000,                4'b0000, 0, 32'h0,      0,   3'd0};
        tbl[10] = '{1, 0, 0, 0, 1, 2'd3, 32'h200,    0,    4'b0000,                4'b1000, 0, 32'h0,      1,   3'd0};
        tbl[11] = '{0, 0, 0, 0, 0, 2'd0, 32'h0,      0,    4'b0000,                4'b0000, 1, 32'h80C,    1,   3'd0};
        tbl[12] = '{0, 0, 0, 0, 0, 2'd0, 32'h0,      NEST, NEST ? 4'b1111 : 4'b0,  4'b0000, 0, 32'h0,      0,   3'd1};

        do_reset();
        chk("rst_IE", 32'(out_IE), 32'h0);
        chk("rst_INM", 32'(out_INM), 32'h0);
        chk("rst_IG", 32'(out_IG), 32'h0);
        chk("rst_jump", 32'(out_jump), 32'h0);
        chk("rst_target", out_target, 32'h0);
        chk("rst_level", 32'(out_level), 32'h0);
        chk("rst_hold", 32'(out_hold), 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].d, tbl[i].e, tbl[i].s, tbl[i].c, tbl[i].b, tbl[i].code, tbl[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_IE", i), 32'(out_IE), 32'(tbl[i].x_ie));
            chk($sformatf("tbl%0d_INM", i), 32'(out_INM), 32'(tbl[i].x_inm));
            chk($sformatf("tbl%0d_IG", i), 32'(out_IG), 32'(tbl[i].x_ig));
            chk($sformatf("tbl%0d_jump", i), 32'(out_jump), 32'(tbl[i].x_jump));
            chk($sformatf("tbl%0d_hold", i), 32'(out_hold), 32'(tbl[i].x_hold));
            chk($sformatf("tbl%0d_level", i), 32'(out_level), 32'(tbl[i].x_lvl));
            if (tbl[i].x_jump) chk($sformatf("tbl%0d_target", i), out_target, tbl[i].x_tgt);
        end

        // reset asserted while the grant is on the bus
        do_reset();
        step(1, 0, 1, 0, 0, 2'd0, 32'h0);
        step(1, 0, 0, 0, 1, 2'd2, 32'h300);
        chk("rstmid_IG_before", 32'(out_IG), 32'h4);
        #2;
        in_RST = 1'b1;
        #1;
        chk("rstmid_IG", 32'(out_IG), 32'h0);
        chk("rstmid_IE", 32'(out_IE), 32'h0);
        chk("rstmid_hold", 32'(out_hold), 32'h0);
        chk("rstmid_jump", 32'(out_jump), 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rstmid_jump_held", 32'(out_jump), 32'h0);
            chk("rstmid_IG_held", 32'(out_IG), 32'h0);
        end
        in_RST = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("rstmid_level", 32'(out_level), 32'h0);

`ifdef NESTED_INT_EN
        // preemption of a code-1 handler by code 3
        do_reset();
        step(1, 0, 1, 0, 0, 2'd0, 32'h0);
        step(1, 0, 0, 0, 1, 2'd1, 32'h100);
        step(0, 0, 0, 0, 0, 2'd0, 32'h0);
        step(0, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("nest_INM1", 32'(out_INM), 32'h3);
        step(1, 0, 0, 0, 1, 2'd3, 32'h204);
        chk("nest_IG", 32'(out_IG), 32'h8);
        step(0, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("nest_vec", out_target, 32'h80C);
        step(0, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("nest_level2", 32'(out_level), 32'h2);
        chk("nest_INM2", 32'(out_INM), 32'hF);
        step(1, 1, 0, 0, 0, 2'd0, 32'h0);
        chk("nest_ret1", out_target, 32'h204);
        step(0, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("nest_INM_back1", 32'(out_INM), 32'h3);
        step(1, 1, 0, 0, 0, 2'd0, 32'h0);
        chk("nest_ret0", out_target, 32'h100);
        step(0, 0, 0, 0, 0, 2'd0, 32'h0);
        chk("nest_INM_back0", 32'(out_INM), 32'h0);
        chk("nest_level0", 32'(out_level), 32'h0);
`endif

        // randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom % 2), ($urandom % 5) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
                 ($urandom % 3) == 0, 2'($urandom % 4), $urandom & 32'hFFFF_FFFC);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_responder.md
Name: int_responder

Overview:
- CPU-side responder to the interrupt priority encoder.
- Consumes the encoder's break/code pair at instruction boundaries and saves the return PC (EPC).
- Issues a one-cycle grant (clear) pulse back to the selected request latch, then redirects fetch to the vector.
- Owns the IE and mask (INM) signals fed to the encoder; handles ERET return.

Parameters:
PC_W, 32, program counter width
VEC_BASE, 32'h0000_0800, address of vector for code 0
VEC_STRIDE, 4, byte distance between vectors
STACK_DEPTH, 4, EPC/mask save depth (used only with NESTED_INT_EN)

Ports:
clk  in  1  system clock, rising edge
in_RST  in  1  reset, asynchronous, active-high
in_break  in  1  interrupt pending from encoder
in_code  in  2  priority code from encoder, 3 = highest
in_instr_done  in  1  current instruction retires this cycle (boundary)
in_pc  in  PC_W  PC of next instruction at boundary
in_eret  in  1  retiring instruction is ERET (valid with in_instr_done)
in_ie_set  in  1  software EI, valid with in_instr_done
in_ie_clr  in  1  software DI, valid with in_instr_done
out_IE  out  1  interrupt enable to encoder
out_INM  out  4  per-level mask to encoder, 1 = masked
out_IG  out  4  one-hot grant pulse, clears request latch
out_hold  out  1  stall fetch/retire
out_jump  out  1  one-cycle PC load strobe
out_target  out  PC_W  PC load value, valid with out_jump
out_level  out  3  current handler nesting depth

Behaviour:
- Reset (async, in_RST=1): state RUN; out_IE=0; out_INM=0; out_IG=0; out_jump=0; out_target=0; out_level=0; EPC/mask storage cleared.
- States: RUN, TAKE, VECTOR, RETURN.
- out_hold=1 in TAKE, VECTOR and RETURN; in those states, in_instr_done/in_eret/in_ie_* are ignored.
- RUN, priority at a boundary (in_instr_done=1):
  - (1) in_eret with out_level>0 → RETURN.
  - (2) else in_break & out_IE → TAKE.
  - (3) else apply in_ie_clr/in_ie_set; clr wins if both are set.
- ERET with out_level=0: no jump, no state change; in_ie_* on that boundary are still applied.
- Entry, boundary at cycle N:
  - Edge ending N: latch code; push EPC=in_pc; out_IE←0; → TAKE.
  - Cycle N+1 (TAKE): out_IG[code]=1, other bits 0.
  - Edge: → VECTOR.
  - Cycle N+2 (VECTOR): out_jump=1; out_target = VEC_BASE + code*VEC_STRIDE (truncated to PC_W).
  - Edge: out_level+1; → RUN.
- Return, boundary at cycle M:
  - Cycle M+1 (RETURN): out_jump=1; out_target = top EPC.
  - Edge: pop; restore out_INM from saved value; out_IE←1; out_level−1; → RUN.
- in_break deasserting during TAKE: grant and vector still complete using the latched code.
- out_IG is never asserted outside TAKE; never more than one bit set.
- Reset mid-sequence: immediate return to reset values; no grant or jump is emitted.

Optional Feature:
Macro: NESTED_INT_EN
- Defined:
  - EPC and INM stack of STACK_DEPTH entries.
  - On VECTOR exit: saved INM is the pre-entry INM; new out_INM = old INM | bits[code:0]; out_IE←1, unless out_level is now STACK_DEPTH, in which case out_IE stays 0 (no overflow possible).
  - A higher code may then preempt.
- Undefined:
  - Single EPC register; out_INM is held at 0.
  - out_IE stays 0 throughout the handler; out_level max 1.
  - Return restores out_IE=1.

Test Plan:
- Reset, then in_ie_set at boundary → out_IE=1 next cycle; out_INM=0, out_level=0.
- out_IE=1, in_break=1, in_code=2, in_pc=0x100, boundary at cycle N:
  - N+1: out_IG=4'b0100, out_IE=0, out_hold=1.
  - N+2: out_jump=1, out_target=0x808.
  - N+3: out_level=1.
- In handler, ERET at boundary → next cycle out_jump=1, out_target=0x100; then out_IE=1, out_level=0.
- ERET with out_level=0 → no out_jump; in_ie_set and in_ie_clr on the same boundary → out_IE=0.
- NESTED_INT_EN, handler code 1 active (out_INM=4'b0011), break code 3 at pc 0x204:
  - Preempt: out_IG=4'b1000, target 0x80C, out_level=2, out_INM=4'b1111.
  - Two ERETs → targets 0x204, then original EPC; out_INM back to 0.
- in_RST asserted in TAKE → out_IG=0, no out_jump, state RUN, out_IE=0.
